// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (imem) and load/store (dmem) requesters
//   clk, rst_n           : clock, asynchronous active-low reset
//   imem_*               : fetch request in (addr, rmask), response out (rdata, resp)
//   dmem_*               : load/store request in (addr, rmask, wmask, wdata), response out (rdata, resp)
//   mem_*                : downstream port, one request at a time, completion on mem_resp
//   proto_err            : sticky, set when a request hits an already-pending slot
//   MEM_ARB_RR_EN        : when defined, round-robin between requesters instead of dmem-first
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH/8-1:0] imem_rmask,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_resp,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH/8-1:0] dmem_rmask,
  input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_resp,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_rmask,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    proto_err
);
  localparam int MW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic                  i_valid, d_valid;
  logic [ADDR_WIDTH-1:0] i_addr, d_addr;
  logic [MW-1:0]         i_rmask, d_rmask, d_wmask;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  owner;
  logic                  grant;
  logic                  i_req, d_req, resp_fwd, i_free, d_free;
  assign i_req    = |imem_rmask;
  assign d_req    = |(dmem_rmask | dmem_wmask);
  assign resp_fwd = (state == WAIT) && mem_resp;
  // a slot being released by this cycle's response may be refilled at the same edge
  assign i_free   = !i_valid || (resp_fwd && !owner);
  assign d_free   = !d_valid || (resp_fwd && owner);
`ifdef MEM_ARB_RR_EN
  logic last_grant;
  assign grant = (i_valid && d_valid) ? !last_grant : d_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b0;
    else if (state == ISSUE) last_grant <= owner;
`else
  assign grant = d_valid;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_addr    <= '0;
      i_rmask   <= '0;
      d_addr    <= '0;
      d_rmask   <= '0;
      d_wmask   <= '0;
      d_wdata   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) owner <= grant;
      if (i_req && i_free) begin
        i_valid <= 1'b1;
        i_addr  <= imem_addr;
        i_rmask <= imem_rmask;
      end else if (resp_fwd && !owner) begin
        i_valid <= 1'b0;
      end
      if (d_req && d_free) begin
        d_valid <= 1'b1;
        d_addr  <= dmem_addr;
        d_rmask <= dmem_rmask;
        d_wmask <= dmem_wmask;
        d_wdata <= dmem_wdata;
      end else if (resp_fwd && owner) begin
        d_valid <= 1'b0;
      end
      if ((i_req && !i_free) || (d_req && !d_free)) proto_err <= 1'b1;
    end
  end
  always_comb begin
    state_nxt  = state;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rmask  = '0;
    mem_wmask  = '0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    if (state == IDLE && (i_valid || d_valid)) state_nxt = ISSUE;
    else if (state == ISSUE) state_nxt = WAIT;
    else if (resp_fwd) state_nxt = IDLE;
    // the owner's slot cannot change until its response, so it holds addr/wdata through WAIT
    if (state == ISSUE || state == WAIT) begin
      mem_addr  = owner ? d_addr : i_addr;
      mem_wdata = owner ? d_wdata : '0;
    end
    if (state == ISSUE) begin
      mem_rmask = owner ? d_rmask : i_rmask;
      mem_wmask = owner ? d_wmask : '0;
    end
    if (resp_fwd) begin
      imem_resp  = !owner;
      dmem_resp  = owner;
      imem_rdata = owner ? '0 : mem_rdata;
      dmem_rdata = owner ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        mem_resp;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_resp, dmem_resp, proto_err;
  logic [3:0]  mem_rmask, mem_wmask;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic [3:0] rm; logic [3:0] wm; logic [31:0] wd;} iss_t;
  typedef struct {logic d; logic [31:0] data;} rsp_t;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int cyc = 0, n_issue = 0, n_resp = 0, issue_cyc = 0, resp_cyc = 0;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_rmask != 0 || mem_wmask != 0) begin
      n_issue++;
      issue_cyc = cyc;
      if (exp_iss.size() == 0) check("unexp_issue", {mem_rmask, mem_wmask}, 0);
      else begin
        iss_t e;
        e = exp_iss.pop_front();
        check("iss_addr", mem_addr, e.addr);
        check("iss_rmask", mem_rmask, e.rm);
        check("iss_wmask", mem_wmask, e.wm);
        check("iss_wdata", mem_wdata, e.wd);
      end
    end
    if (imem_resp || dmem_resp) begin
      n_resp++;
      resp_cyc = cyc;
      if (exp_rsp.size() == 0) check("unexp_resp", {dmem_resp, imem_resp}, 0);
      else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        check("resp_who", {dmem_resp, imem_resp}, r.d ? 2'b10 : 2'b01);
        check("resp_data", r.d ? dmem_rdata : imem_rdata, r.data);
        check("resp_other_rdata", r.d ? imem_rdata : dmem_rdata, 0);
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req_i(input logic [31:0] a);
    imem_addr = a; imem_rmask = 4'hF;
    step();
    imem_rmask = 4'h0;
  endtask
  task automatic req_d(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    step();
    dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = '0;
  endtask
  task automatic wait_issue(input int start);
    int k = 0;
    while (n_issue == start && k < 40) begin
      step();
      k++;
    end
    check("issued", 64'(n_issue != start), 1);
  endtask
  task automatic respond(input int lat, input logic d, input logic [31:0] data);
    if (lat > 1) step(lat - 1);
    mem_resp = 1'b1; mem_rdata = data;
    exp_rsp.push_back(rsp_t'{d, data});
    step();
    mem_resp = 1'b0; mem_rdata = '0;
  endtask
  task automatic serve(input int start, input int lat, input logic d, input logic [31:0] data);
    wait_issue(start);
    respond(lat, d, data);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_mem"}, {mem_rmask, mem_wmask, mem_addr}, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_resp"}, {imem_resp, dmem_resp, proto_err, imem_rdata}, 0);
    check({tag, "_drdata"}, dmem_rdata, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s, cap, r;
    rst_n = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    imem_addr = '0; imem_rmask = '0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    step(2);
    check_zero("reset");
    rst_n = 1'b1;
    step();
    // fetch while idle
    s = n_issue;
    exp_iss.push_back(iss_t'{32'h6000_0000, 4'hF, 4'h0, 32'h0});
    req_i(32'h6000_0000);
    cap = cyc;
    serve(s, 3, 1'b0, 32'h0000_0013);
    check("fetch_lat", issue_cyc, cap + 1);
    check("fetch_resp_lat", resp_cyc, issue_cyc + 3);
    step(2);
    check("fetch_one_issue", n_issue - s, 1);
    // back-to-back loads from dmem, second raised in the first's response cycle
    s = n_issue;
    exp_iss.push_back(iss_t'{32'h6000_2000, 4'h1, 4'h0, 32'h0});
    req_d(32'h6000_2000, 4'h1, 4'h0, 32'h0);
    wait_issue(s);
    dmem_addr = 32'h6000_2004; dmem_rmask = 4'h1;
    exp_iss.push_back(iss_t'{32'h6000_2004, 4'h1, 4'h0, 32'h0});
    respond(1, 1'b1, 32'h0000_0011);
    dmem_rmask = 4'h0;
    serve(n_issue, 2, 1'b1, 32'h0000_0022);
    step(2);
    check("b2b_proto", proto_err, 0);
    check("b2b_loads", n_issue - s, 2);
    // simultaneous fetch and store
    imem_addr = 32'h6000_0004; imem_rmask = 4'hF;
    dmem_addr = 32'h6000_1000; dmem_wmask = 4'h3; dmem_wdata = 32'hDEAD_BEEF;
`ifdef MEM_ARB_RR_EN
    exp_iss.push_back(iss_t'{32'h6000_0004, 4'hF, 4'h0, 32'h0});
    exp_iss.push_back(iss_t'{32'h6000_1000, 4'h0, 4'h3, 32'hDEAD_BEEF});
`else
    exp_iss.push_back(iss_t'{32'h6000_1000, 4'h0, 4'h3, 32'hDEAD_BEEF});
    exp_iss.push_back(iss_t'{32'h6000_0004, 4'hF, 4'h0, 32'h0});
`endif
    s = n_issue;
    step();
    imem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = '0;
`ifdef MEM_ARB_RR_EN
    serve(s, 2, 1'b0, 32'h0010_0093);
    r = resp_cyc;
    serve(n_issue, 2, 1'b1, 32'h0);
`else
    serve(s, 2, 1'b1, 32'h0);
    r = resp_cyc;
    serve(n_issue, 2, 1'b0, 32'h0010_0093);
`endif
    check("sim_gap", issue_cyc, r + 2);
    step(2);
    check("sim_proto", proto_err, 0);
    // protocol violation: second fetch while the first is pending
    s = n_issue;
    exp_iss.push_back(iss_t'{32'h6000_0008, 4'hF, 4'h0, 32'h0});
    req_i(32'h6000_0008);
    req_i(32'h6000_000C);
    check("proto_set", proto_err, 1);
    serve(s, 2, 1'b0, 32'h0000_0033);
    step(3);
    check("proto_one_read", n_issue - s, 1);
    check("proto_sticky", proto_err, 1);
    mem_rdata = 32'h5555_5555;
    #1;
    check("idle_rdata", {imem_rdata, dmem_rdata}, 0);
    mem_rdata = '0;
    // reset while waiting on a fetch
    s = n_issue;
    exp_iss.push_back(iss_t'{32'h6000_0010, 4'hF, 4'h0, 32'h0});
    req_i(32'h6000_0010);
    wait_issue(s);
    step();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    r = n_resp;
    mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    check("late_resp_now", {imem_resp, dmem_resp}, 0);
    step();
    mem_resp = 1'b0; mem_rdata = '0;
    step(2);
    check("late_resp", n_resp - r, 0);
    check("late_issue", n_issue - s, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
